// File: rtl/pe_mem_arbiter.sv
// pe_mem_arbiter: shares one single-ported PE-local SRAM between the DMA
// engine and the PE load/store unit. Load/store normally wins; a DMA that has
// been refused STARVE_MAX cycles in a row gets one forced grant. Read owners
// travel down a fixed-latency tag pipeline so each response returns to the
// requester that issued it.
//
// Handshake: a request is accepted in any cycle where valid && ready. Ready is
// combinational from this cycle's grant. Requesters hold valid/wr/addr/data
// stable until accepted. Responses have no ready: they cannot be stalled.
module pe_mem_arbiter #(
  parameter int ADDR_W     = 12,
  parameter int DATA_W     = 32,
  parameter int RD_LAT     = 2,
  parameter int STARVE_MAX = 4
) (
  input  logic              clk,
  input  logic              reset_poweron,
  // DMA request / response
  input  logic              dma2mem_valid,
  output logic              dma2mem_ready,
  input  logic              dma2mem_wr,
  input  logic [ADDR_W-1:0] dma2mem_addr,
  input  logic [DATA_W-1:0] dma2mem_data,
  output logic              mem2dma_valid,
  output logic [DATA_W-1:0] mem2dma_data,
  // load/store request / response
  input  logic              ls2mem_valid,
  output logic              ls2mem_ready,
  input  logic              ls2mem_wr,
  input  logic [ADDR_W-1:0] ls2mem_addr,
  input  logic [DATA_W-1:0] ls2mem_data,
  output logic              mem2ls_valid,
  output logic [DATA_W-1:0] mem2ls_data,
  // SRAM macro
  output logic              sram_en,
  output logic              sram_we,
  output logic [ADDR_W-1:0] sram_addr,
  output logic [DATA_W-1:0] sram_wdata,
  input  logic [DATA_W-1:0] sram_rdata,
  // debug visibility of the arbiter FSM
  output logic              dbg_state,
  output logic [3:0]        dbg_starve_cnt
);

  typedef enum logic {
    LS_PRIO   = 1'b0,
    DMA_FORCE = 1'b1
  } arb_state_t;

  arb_state_t  state, state_next;
  logic [3:0]  starve_cnt, starve_next;
  logic        grant_ls, grant_dma, grant_any;
  logic        push_v, push_o;
  // tag_o: 1 = DMA owns the read, 0 = load/store owns it
  logic [RD_LAT-1:0] tag_v, tag_o;
  logic        resp_v;

  // Grant selection, next counter value and next FSM state
  always_comb begin
    grant_ls    = 1'b0;
    grant_dma   = 1'b0;
    starve_next = 4'd0;
    state_next  = state;
    if (!reset_poweron) begin
      if (state == DMA_FORCE) begin
        // DMA holds valid until accepted, so the LS fallback only keeps the
        // port busy if a requester misbehaves.
        if (dma2mem_valid)     grant_dma = 1'b1;
        else if (ls2mem_valid) grant_ls  = 1'b1;
      end else begin
        if (ls2mem_valid)       grant_ls  = 1'b1;
        else if (dma2mem_valid) grant_dma = 1'b1;
      end
    end
    if (dma2mem_valid && !grant_dma)
      starve_next = (starve_cnt == 4'd15) ? 4'd15 : starve_cnt + 4'd1;
    case (state)
      LS_PRIO:   if (starve_next >= 4'(STARVE_MAX)) state_next = DMA_FORCE;
      DMA_FORCE: if (grant_dma)                     state_next = LS_PRIO;
      default:   state_next = LS_PRIO;
    endcase
  end

  assign grant_any     = grant_ls | grant_dma;
  assign ls2mem_ready  = grant_ls;
  assign dma2mem_ready = grant_dma;

  // SRAM port drive muxed from the granted requester, zero when idle
  always_comb begin
    sram_en    = grant_any;
    sram_we    = 1'b0;
    sram_addr  = '0;
    sram_wdata = '0;
    if (grant_ls) begin
      sram_we    = ls2mem_wr;
      sram_addr  = ls2mem_addr;
      sram_wdata = ls2mem_data;
    end else if (grant_dma) begin
      sram_we    = dma2mem_wr;
      sram_addr  = dma2mem_addr;
      sram_wdata = dma2mem_data;
    end
  end

  assign push_v = (grant_ls && !ls2mem_wr) || (grant_dma && !dma2mem_wr);
  assign push_o = grant_dma;

  // FSM state and starvation counter registers
  always_ff @(posedge clk) begin
    if (reset_poweron) begin
      state      <= LS_PRIO;
      starve_cnt <= 4'd0;
    end else begin
      state      <= state_next;
      starve_cnt <= starve_next;
    end
  end

  // Read tag pipeline: one stage per cycle of SRAM read latency
  always_ff @(posedge clk) begin
    if (reset_poweron) begin
      tag_v <= '0;
      tag_o <= '0;
    end else begin
      for (int i = RD_LAT - 1; i > 0; i--) begin
        tag_v[i] <= tag_v[i-1];
        tag_o[i] <= tag_o[i-1];
      end
      tag_v[0] <= push_v;
      tag_o[0] <= push_v & push_o;
    end
  end

  // The last stage lines up with sram_rdata; reset drops in-flight reads
  assign resp_v        = tag_v[RD_LAT-1] && !reset_poweron;
  assign mem2ls_valid  = resp_v && !tag_o[RD_LAT-1];
  assign mem2dma_valid = resp_v &&  tag_o[RD_LAT-1];
  assign mem2ls_data   = mem2ls_valid  ? sram_rdata : '0;
  assign mem2dma_data  = mem2dma_valid ? sram_rdata : '0;

  assign dbg_state      = state;
  assign dbg_starve_cnt = starve_cnt;

endmodule

// File: tb/tb_pe_mem_arbiter.sv
// Testbench for pe_mem_arbiter: directed vectors, SRAM behavioural model,
// response scoreboard with per-requester expected queues.
module tb_pe_mem_arbiter;

  localparam int ADDR_W = 12;
  localparam int DATA_W = 32;
  localparam int RD_LAT = 2;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic reset_poweron = 1'b1;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // ---------------- DUT ----------------
  logic              dma2mem_valid = 0, dma2mem_wr = 0;
  logic [ADDR_W-1:0] dma2mem_addr = '0;
  logic [DATA_W-1:0] dma2mem_data = '0;
  logic              ls2mem_valid = 0, ls2mem_wr = 0;
  logic [ADDR_W-1:0] ls2mem_addr = '0;
  logic [DATA_W-1:0] ls2mem_data = '0;
  logic              dma2mem_ready, ls2mem_ready;
  logic              mem2dma_valid, mem2ls_valid;
  logic [DATA_W-1:0] mem2dma_data, mem2ls_data;
  logic              sram_en, sram_we;
  logic [ADDR_W-1:0] sram_addr;
  logic [DATA_W-1:0] sram_wdata, sram_rdata;
  logic              dbg_state;
  logic [3:0]        dbg_starve_cnt;

  pe_mem_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .RD_LAT(RD_LAT), .STARVE_MAX(4)) dut (
    .clk(clk), .reset_poweron(reset_poweron),
    .dma2mem_valid(dma2mem_valid), .dma2mem_ready(dma2mem_ready), .dma2mem_wr(dma2mem_wr),
    .dma2mem_addr(dma2mem_addr), .dma2mem_data(dma2mem_data),
    .mem2dma_valid(mem2dma_valid), .mem2dma_data(mem2dma_data),
    .ls2mem_valid(ls2mem_valid), .ls2mem_ready(ls2mem_ready), .ls2mem_wr(ls2mem_wr),
    .ls2mem_addr(ls2mem_addr), .ls2mem_data(ls2mem_data),
    .mem2ls_valid(mem2ls_valid), .mem2ls_data(mem2ls_data),
    .sram_en(sram_en), .sram_we(sram_we), .sram_addr(sram_addr),
    .sram_wdata(sram_wdata), .sram_rdata(sram_rdata),
    .dbg_state(dbg_state), .dbg_starve_cnt(dbg_starve_cnt)
  );

  // ---------------- SRAM model (write-first, 2-cycle read) ----------------
  // Contents default to addr+0x100; word 0x010 holds 0xDEADBEEF.
  logic [DATA_W-1:0] mem [1<<ADDR_W];
  logic [DATA_W-1:0] rd0 = '0, rd1 = '0;
  logic              mem_init_done = 1'b0;
  always @(posedge clk) begin
    if (!mem_init_done) begin
      for (int i = 0; i < (1<<ADDR_W); i++) mem[i] = DATA_W'(i + 32'h100);
      mem[12'h010] = 32'hDEADBEEF;
      mem_init_done <= 1'b1;
    end else if (sram_en) begin
      if (sram_we) mem[sram_addr] <= sram_wdata;
      rd0 <= sram_we ? sram_wdata : mem[sram_addr];
    end
    rd1 <= rd0;
  end
  assign sram_rdata = rd1;

  // ---------------- scoreboard ----------------
  int n_tests = 0;
  int n_fail  = 0;
  logic [DATA_W-1:0] ls_exp_q[$];
  logic [DATA_W-1:0] dma_exp_q[$];
  int                ls_cyc_q[$];
  int                dma_cyc_q[$];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s @cyc %0d: got 0x%0h expected 0x%0h", name, cyc, act, exp);
    end
  endtask

  // Monitor: every response valid pops its requester's queue
  always @(negedge clk) begin
    if (mem2ls_valid) begin
      if (ls_exp_q.size() == 0) chk("ls_resp_unexpected", 1, 0);
      else begin
        chk("ls_resp_data", mem2ls_data, ls_exp_q.pop_front());
        chk("ls_resp_cycle", cyc, ls_cyc_q.pop_front());
      end
    end else chk("ls_idle_data", mem2ls_data, 0);
    if (mem2dma_valid) begin
      if (dma_exp_q.size() == 0) chk("dma_resp_unexpected", 1, 0);
      else begin
        chk("dma_resp_data", mem2dma_data, dma_exp_q.pop_front());
        chk("dma_resp_cycle", cyc, dma_cyc_q.pop_front());
      end
    end else chk("dma_idle_data", mem2dma_data, 0);
  end

  // ---------------- driver ----------------
  // One cycle of stimulus with hand-computed grant; accepted reads with
  // push=1 queue their expected data for cycle cyc+RD_LAT.
  task automatic step(input logic rst,
                      input logic lv, input logic lw, input logic [ADDR_W-1:0] la, input logic [DATA_W-1:0] ld,
                      input logic dv, input logic dw, input logic [ADDR_W-1:0] da, input logic [DATA_W-1:0] dd,
                      input logic e_lr, input logic e_dr, input logic push,
                      input logic [DATA_W-1:0] e_ld, input logic [DATA_W-1:0] e_dd,
                      input int e_cnt, input int e_st);
    logic              e_we;
    logic [ADDR_W-1:0] e_addr;
    logic [DATA_W-1:0] e_wd;
    reset_poweron = rst;
    ls2mem_valid = lv;  ls2mem_wr = lw;  ls2mem_addr = la;  ls2mem_data = ld;
    dma2mem_valid = dv; dma2mem_wr = dw; dma2mem_addr = da; dma2mem_data = dd;
    e_we   = e_lr ? lw : (e_dr ? dw : 1'b0);
    e_addr = e_lr ? la : (e_dr ? da : '0);
    e_wd   = e_lr ? ld : (e_dr ? dd : '0);
    if (push && e_lr && !lw) begin ls_exp_q.push_back(e_ld);  ls_cyc_q.push_back(cyc + RD_LAT);  end
    if (push && e_dr && !dw) begin dma_exp_q.push_back(e_dd); dma_cyc_q.push_back(cyc + RD_LAT); end
    @(negedge clk);
    chk("ls_ready", ls2mem_ready, e_lr);
    chk("dma_ready", dma2mem_ready, e_dr);
    chk("sram_en", sram_en, e_lr | e_dr);
    chk("sram_we", sram_we, e_we);
    chk("sram_addr", sram_addr, e_addr);
    chk("sram_wdata", sram_wdata, e_wd);
    if (e_cnt >= 0) chk("starve_cnt", dbg_starve_cnt, e_cnt);
    if (e_st  >= 0) chk("arb_state", dbg_state, e_st);
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(0, 0,0,'0,'0, 0,0,'0,'0, 0,0,0,'0,'0, -1,-1);
  endtask

  // Watchdog
  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "timeout");
  end

  // ---------------- directed tests ----------------
  initial begin
    int li, di;
    // Reset with both requesters asserting: nothing may be granted
    @(posedge clk); #1;
    for (int i = 0; i < 3; i++)
      step(1, 1,0,12'h005,'0, 1,0,12'h006,'0, 0,0,0,'0,'0, -1,-1);
    idle(1);
    step(0, 0,0,'0,'0, 0,0,'0,'0, 0,0,0,'0,'0, 0,0);

    // 1: lone LS read of preloaded word
    step(0, 1,0,12'h010,'0, 0,0,'0,'0, 1,0,1,32'hDEADBEEF,'0, 0,0);
    idle(3);

    // 2: both reading continuously -> LS,LS,LS,LS,DMA repeating
    li = 0; di = 0;
    for (int k = 0; k < 10; k++) begin
      logic gl;
      gl = (k % 5) != 4;
      step(0, 1,0,ADDR_W'(12'h040 + li),'0, 1,0,ADDR_W'(12'h080 + di),'0,
           gl, !gl, 1, 32'h140 + li, 32'h180 + di, k % 5, (k % 5 == 4) ? 1 : 0);
      if (gl) li++; else di++;
    end
    step(0, 0,0,'0,'0, 0,0,'0,'0, 0,0,0,'0,'0, 0,0);
    idle(3);

    // 3: alternating single reads, back-to-back responses
    step(0, 1,0,12'h001,'0, 0,0,'0,'0,     1,0,1,32'h101,'0, -1,-1);
    step(0, 0,0,'0,'0,      1,0,12'h002,'0, 0,1,1,'0,32'h102, -1,-1);
    step(0, 1,0,12'h003,'0, 0,0,'0,'0,     1,0,1,32'h103,'0, -1,-1);
    idle(3);

    // 4: DMA write then LS read of same address next cycle
    step(0, 0,0,'0,'0, 1,1,12'h020,32'h55AA, 0,1,1,'0,'0, -1,-1);
    step(0, 1,0,12'h020,'0, 0,0,'0,'0, 1,0,1,32'h55AA,'0, -1,-1);
    idle(3);

    // 5: two reads in flight, then 1-cycle reset drops them
    step(0, 1,0,12'h010,'0, 0,0,'0,'0,     1,0,0,'0,'0, -1,-1);
    step(0, 0,0,'0,'0,      1,0,12'h030,'0, 0,1,0,'0,'0, -1,-1);
    step(1, 1,0,12'h031,'0, 1,0,12'h032,'0, 0,0,0,'0,'0, -1,-1);
    step(0, 0,0,'0,'0, 0,0,'0,'0, 0,0,0,'0,'0, 0,0);
    idle(2);
    step(0, 1,0,12'h011,'0, 0,0,'0,'0, 1,0,1,32'h111,'0, 0,0);
    idle(3);

    // 6: DMA alone for 10 cycles: granted every cycle, no starvation
    for (int i = 0; i < 10; i++)
      step(0, 0,0,'0,'0, 1,0,ADDR_W'(12'h200 + i),'0, 0,1,1,'0,32'h300 + i, 0,0);
    idle(4);

    chk("ls_queue_drained", ls_exp_q.size(), 0);
    chk("dma_queue_drained", dma_exp_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/pe_mem_arbiter.md
Name: pe_mem_arbiter

Overview:
- Arbitrates one single-ported PE-local SRAM between two requesters: the DMA engine (dma2mem path) and the PE load/store unit (loadStore2memCntl path).
- Grants at most one access per cycle, with load/store priority and a DMA anti-starvation override.
- Tracks in-flight reads through a fixed-latency tag pipeline and routes each read response back to the requester that issued it.
- Sits between the two requesters and the SRAM macro inside each PE.

Parameters:
ADDR_W, 12, SRAM word-address width
DATA_W, 32, SRAM data width
RD_LAT, 2, SRAM read latency in cycles, from address-sampling edge to rdata valid (legal range 1..4)
STARVE_MAX, 4, consecutive denied DMA cycles before DMA is forced ahead (legal range 1..15)

Ports:
clk  in  1  system clock
reset_poweron  in  1  synchronous reset, active-high
dma2mem_valid  in  1  DMA request valid
dma2mem_ready  out  1  DMA request granted this cycle
dma2mem_wr  in  1  1 = write, 0 = read
dma2mem_addr  in  ADDR_W  DMA address
dma2mem_data  in  DATA_W  DMA write data
mem2dma_valid  out  1  DMA read response valid
mem2dma_data  out  DATA_W  DMA read response data
ls2mem_valid  in  1  load/store request valid
ls2mem_ready  out  1  load/store request granted this cycle
ls2mem_wr  in  1  1 = store, 0 = load
ls2mem_addr  in  ADDR_W  load/store address
ls2mem_data  in  DATA_W  store data
mem2ls_valid  out  1  load response valid
mem2ls_data  out  DATA_W  load response data
sram_en  out  1  SRAM access enable
sram_we  out  1  SRAM write enable
sram_addr  out  ADDR_W  SRAM address
sram_wdata  out  DATA_W  SRAM write data
sram_rdata  in  DATA_W  SRAM read data, valid RD_LAT cycles after sampling

Behaviour:
- Handshake: a request is accepted in a cycle where valid and ready are both high. Ready is combinational from the current-cycle grant. Requesters must hold valid, wr, addr and data stable until accepted.
- Arbiter states:
  - LS_PRIO (reset state): grant LS if ls2mem_valid, else DMA if dma2mem_valid.
  - DMA_FORCE: grant DMA unconditionally.
- Starve counter (4 bits):
  - Increments each cycle that dma2mem_valid=1 and DMA is not granted; saturates at 15.
  - Clears whenever DMA is granted, or when dma2mem_valid=0.
- State transitions:
  - LS_PRIO -> DMA_FORCE when the counter reaches STARVE_MAX at a clock edge.
  - DMA_FORCE -> LS_PRIO after exactly one DMA grant.
  - A forced DMA grant takes precedence even when LS is valid in the same cycle.
- SRAM drive (combinational from the grant):
  - sram_en = grant_any.
  - sram_we, sram_addr, sram_wdata are muxed from the granted requester.
  - When there is no grant: sram_en=0, sram_we=0, addr/wdata hold 0.
- Read tag pipeline: RD_LAT-deep shift register of {valid, owner}. An accepted read pushes {1, owner}; a write or idle cycle pushes {0, x}.
- Response routing: for a read accepted in cycle t, during cycle t+RD_LAT the owner's memX_valid=1 and memX_data=sram_rdata. The other requester's response stays valid=0.
  - Responses cannot be back-pressured.
  - Responses return in issue order.
  - One response per cycle at most.
  - Response data is 0 whenever its valid is 0.
- Read/write ordering: a write accepted in cycle t followed by a read of the same address in cycle t+1 returns the new data (the SRAM is write-first; the arbiter adds no reordering).
- Reset (sampled at clk edge):
  - State -> LS_PRIO; counter -> 0; tag pipeline cleared.
  - In-flight reads are dropped and never produce a response.
  - While reset_poweron=1, both readys, sram_en and sram_we are 0, and both response valids are 0.
- Reset values of all outputs: 0.
- Throughput: one access per cycle, no bubbles between consecutive grants, including owner switches.

Test Plan:
- SRAM addr 0x010 preloaded with 0xDEADBEEF; LS read of 0x010 alone -> ls2mem_ready=1 in the request cycle; mem2ls_valid=1 with data 0xDEADBEEF exactly 2 cycles later; mem2dma_valid stays 0 throughout.
- Both requesters valid continuously, reads, STARVE_MAX=4 -> grant sequence LS,LS,LS,LS,DMA repeating; counter returns to 0 after each DMA grant.
- Alternating single-cycle reads LS@0x1, DMA@0x2, LS@0x3 with the mem holding addr+0x100 -> responses on consecutive cycles 0x101 (LS), 0x102 (DMA), 0x103 (LS), with no bubbles.
- DMA write 0x55AA to 0x20, then LS read of 0x20 on the next cycle -> mem2ls_data=0x55AA; sram_we is high only on the write cycle.
- Two reads in flight, reset_poweron asserted for 1 cycle -> no response valids afterwards; both readys 0 during reset; after reset, a new LS read completes in RD_LAT cycles.
- DMA valid alone for 10 cycles -> granted every cycle; state stays LS_PRIO; counter stays 0.
